tdm_demux8: RTL
===============

# tdm_demux8

Eight-channel time-division demultiplexer: the receive end of the 8-to-1 nibble multiplexer path. A serial stream of 4-bit words, one channel per slot, is routed back to eight parallel channel registers. The block uses a start-of-frame marker to stay aligned and publishes a complete frame atomically. It sits between the serial link and the per-channel consumers (LED/7-seg logic, function evaluators).

## Interface
- `NCH`, 8: channels per frame; fixed at 8 (3-bit slot index).
- `W`, 4: bits per channel word.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `E` in 1: enable; when low, the block ignores input and holds all state.
- `din` in W: channel word for the current slot.
- `din_valid` in 1: `din` carries a word this cycle.
- `sof` in 1: qualifies `din`/`din_valid` and marks the channel-0 slot.
- `dout` out NCH*W: published frame; channel k at bits [4k+3:4k].
- `frame_valid` out 1: one-cycle pulse when `dout` is updated.
- `sel` out 3: slot index expected for the next accepted word.
- `locked` out 1: high when the FSM is in SYNC.
- `sync_err` out 1: one-cycle pulse on a framing violation.

## Operation
- Accepted word: `E && din_valid`. No other input condition has any effect.
- FSM states: HUNT and SYNC. Reset state is HUNT.
- Internal shadow bank holds NCH×W bits; `dout` is loaded only from the shadow bank plus the final word.
- In HUNT:
  - accepted word with `sof`=1: write shadow[0], set `sel`=1, go to SYNC.
  - accepted word with `sof`=0: discard it; no error is flagged.
- In SYNC, `sel`=0, accepted word:
  - `sof`=1: write shadow[0], set `sel`=1.
  - `sof`=0: pulse `sync_err`, discard the word, go to HUNT, set `sel`=0.
- In SYNC, `sel` in 1..6, accepted word:
  - `sof`=0: write shadow[sel], increment `sel`.
  - `sof`=1: early SOF. Pulse `sync_err` and drop the partial frame. The word is taken as channel 0: write shadow[0], set `sel`=1, stay in SYNC.
- In SYNC, `sel`=7, accepted word:
  - `sof`=0: load `dout` from shadow[0..6] plus `din` as channel 7, pulse `frame_valid`, wrap `sel` to 0.
  - `sof`=1: same as the early-SOF case.
- `E` low: `sel`, state, shadow bank and `dout` hold; `frame_valid` and `sync_err` stay 0.
- Reset mid-frame: the partial frame is lost and `dout` is cleared.
- `dout` holds its last frame until the next complete frame; partial frames are never visible on it.

## Timing
- Reset values:
  - `dout`=0, `frame_valid`=0, `sel`=0, `locked`=0, `sync_err`=0; shadow bank=0.
  - `err_cnt`=0 when the counter is compiled in.
- All outputs are registered.
- Latency: `dout`/`frame_valid` update on the clock edge that accepts the channel-7 word, so they are visible in the following cycle.
- `sync_err` is asserted in the cycle after the offending word.
- Back-to-back frames at full rate (one word per cycle) are supported with no bubble.
- `locked` reflects the state register directly.

## Configuration
- `TDM_DEMUX_ERRCNT_EN` defined:
  - adds output port `err_cnt` out 8.
  - the counter increments on every `sync_err` pulse and saturates at 8'hFF.
  - it clears only on `rst`.
- Not defined: the port and the counter are absent; all other behaviour is identical.

## Structure
- Package `tdm_pkg` holds:
  - constants `TDM_NCH`=8, `TDM_W`=4;
  - the state enum `tdm_state_t` {HUNT, SYNC};
  - typedef `tdm_word_t` (logic [3:0]).
- One sub-module, `tdm_sync_fsm`: the HUNT/SYNC state register and `sel` counter. It produces write-enable, slot index, publish and error strobes.
- The top level holds the shadow bank, the `dout` register and the optional error counter.

## Test plan
- Reset → all outputs 0; `locked`=0.
- Aligned frame: with `E`=1, send words 1..8 on consecutive cycles, `sof` only on the first. Required: `frame_valid` pulses once, `dout`=32'h87654321, `locked`=1, `sel` returns to 0.
- Early SOF:
  - after 3 words of a frame, send `sof` with `din`=4'hA, then 7 more words 4'h1.
  - Required: one `sync_err` pulse; next `dout`=32'h1111111A; the old `dout` is unchanged until then.
- Missing SOF: after a complete frame, send a word with `sof`=0. Required: `sync_err` pulse, `locked`=0, then no `frame_valid` until a new `sof`.
- Enable and reset gating:
  - drop `E` for 5 cycles mid-frame while `din_valid`=1. Required: the frame completes correctly once `E` returns, with no extra words captured.
  - assert `rst` mid-frame. Required: `dout`=0, `locked`=0.
- With `TDM_DEMUX_ERRCNT_EN`: force 300 framing errors. Required: `err_cnt` saturates at 8'hFF.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared constants and types for the eight-channel TDM demultiplexer.
package tdm_pkg;

  localparam int TDM_NCH = 8;
  localparam int TDM_W   = 4;

  // HUNT: waiting for a start-of-frame word. SYNC: aligned to the frame.
  typedef enum logic {
    HUNT = 1'b0,
    SYNC = 1'b1
  } tdm_state_t;

  typedef logic [TDM_W-1:0] tdm_word_t;

endpackage

// File: rtl/tdm_sync_fsm.sv
// Frame alignment FSM for tdm_demux8: tracks HUNT/SYNC and the expected
// slot index, and emits shadow write, publish and framing-error strobes
// for the word accepted this cycle.
module tdm_sync_fsm
  import tdm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       accept,
  input  logic       sof,
  output logic       wr_en,
  output logic [2:0] wr_idx,
  output logic       publish,
  output logic       err,
  output logic [2:0] sel,
  output logic       locked
);

  tdm_state_t state_q, state_d;
  logic [2:0] sel_q, sel_d;

  // State and slot counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      sel_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // Next-state logic and per-word strobes; nothing happens without an accepted word.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    wr_en   = 1'b0;
    wr_idx  = sel_q;
    publish = 1'b0;
    err     = 1'b0;
    if (accept) begin
      case (state_q)
        HUNT: begin
          // Words without sof are silently discarded while hunting.
          if (sof) begin
            wr_en   = 1'b1;
            wr_idx  = 3'd0;
            sel_d   = 3'd1;
            state_d = SYNC;
          end
        end
        SYNC: begin
          if (sel_q == 3'd0) begin
            if (sof) begin
              wr_en  = 1'b1;
              wr_idx = 3'd0;
              sel_d  = 3'd1;
            end else begin
              // Channel-0 slot without sof: alignment lost.
              err     = 1'b1;
              sel_d   = 3'd0;
              state_d = HUNT;
            end
          end else if (sof) begin
            // Early sof: abandon the partial frame, restart at channel 0.
            err    = 1'b1;
            wr_en  = 1'b1;
            wr_idx = 3'd0;
            sel_d  = 3'd1;
          end else if (sel_q == 3'd7) begin
            // Last channel goes straight into dout, never into the shadow.
            publish = 1'b1;
            sel_d   = 3'd0;
          end else begin
            wr_en = 1'b1;
            sel_d = sel_q + 3'd1;
          end
        end
        default: begin
          state_d = HUNT;
          sel_d   = 3'd0;
        end
      endcase
    end
  end

  assign sel    = sel_q;
  assign locked = (state_q == SYNC);

endmodule

// File: rtl/tdm_demux8.sv
// Eight-channel TDM nibble demultiplexer. Words are staged in a shadow
// bank and published to dout atomically with the channel-7 word.
// Optional feature macro: TDM_DEMUX_ERRCNT_EN adds a saturating 8-bit
// framing-error counter on port err_cnt.
module tdm_demux8
  import tdm_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     E,
  input  logic [TDM_W-1:0]         din,
  input  logic                     din_valid,
  input  logic                     sof,
  output logic [TDM_NCH*TDM_W-1:0] dout,
  output logic                     frame_valid,
  output logic [2:0]               sel,
  output logic                     locked,
  output logic                     sync_err
`ifdef TDM_DEMUX_ERRCNT_EN
  ,
  output logic [7:0]               err_cnt
`endif
);

  logic       accept;
  logic       wr_en;
  logic [2:0] wr_idx;
  logic       publish;
  logic       err;

  assign accept = E && din_valid;

  tdm_sync_fsm u_fsm (
    .clk     (clk),
    .rst     (rst),
    .accept  (accept),
    .sof     (sof),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .publish (publish),
    .err     (err),
    .sel     (sel),
    .locked  (locked)
  );

  tdm_word_t shadow_q [TDM_NCH-1];
  logic [TDM_NCH*TDM_W-1:0] frame_next;
  logic [TDM_NCH*TDM_W-1:0] dout_q, dout_d;
  logic frame_valid_q, frame_valid_d;
  logic sync_err_q, sync_err_d;

  genvar gi;
  generate
    for (gi = 0; gi < TDM_NCH - 1; gi++) begin : g_shadow
      // Shadow slot gi captures the word written for channel gi.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          shadow_q[gi] <= '0;
        end else if (wr_en && (wr_idx == 3'(gi))) begin
          shadow_q[gi] <= din;
        end
      end
      assign frame_next[gi*TDM_W +: TDM_W] = shadow_q[gi];
    end
  endgenerate

  assign frame_next[(TDM_NCH-1)*TDM_W +: TDM_W] = din;

  // Output register next values: dout changes only on a completed frame.
  always_comb begin
    dout_d        = dout_q;
    frame_valid_d = publish;
    sync_err_d    = err;
    if (publish) begin
      dout_d = frame_next;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q        <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      dout_q        <= dout_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign dout        = dout_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;

`ifdef TDM_DEMUX_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating count of framing errors; only reset clears it.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Error counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
